// File: rtl/cache_flush_seq.sv
// Flush sequencer for one set-associative L1 cache: waits for the write buffer
// to drain, then clears every way's valid bits set by set through the tag port.
module cache_flush_seq #(
    parameter int  CACHE_BYTE_SIZE = 2261,
    parameter int  SET_ASSOC       = 2,
    parameter int  LINE_WIDTH      = 128,
    localparam int NUM_SETS        = CACHE_BYTE_SIZE / (SET_ASSOC * LINE_WIDTH / 8),
    localparam int IDX_W           = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_req_i,
    input  logic                 wbuf_empty_i,
    output logic                 tag_req_o,
    input  logic                 tag_gnt_i,
    output logic                 tag_we_o,
    output logic [IDX_W-1:0]     tag_idx_o,
    output logic [SET_ASSOC-1:0] tag_way_o,
    output logic                 busy_o,
    output logic                 flush_ack_o,
    output logic [15:0]          flush_cnt_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        INVAL = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SETS - 1);

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 redo_q, redo_d;
    logic [15:0]          cnt_q, cnt_d;

    logic                 busy_q;
    logic                 tag_req_q;
    logic [IDX_W-1:0]     tag_idx_q;
    logic [SET_ASSOC-1:0] tag_way_q;
    logic                 ack_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        redo_d  = redo_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (flush_req_i) state_d = DRAIN;
            end
            DRAIN: begin
                // A request here is covered by the walk that has not started yet.
                if (wbuf_empty_i) begin
                    state_d = INVAL;
                    idx_d   = '0;
                end
            end
            INVAL: begin
                if (flush_req_i) redo_d = 1'b1;
                if (tag_gnt_i) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            DONE: begin
                if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
                // A request arriving in DONE is coalesced with any pending redo.
                if (redo_q || flush_req_i) begin
                    state_d = DRAIN;
                    redo_d  = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next-state decode, so they line up with state_q.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            redo_q    <= 1'b0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            tag_req_q <= 1'b0;
            tag_idx_q <= '0;
            tag_way_q <= '0;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            redo_q    <= redo_d;
            cnt_q     <= cnt_d;
            busy_q    <= (state_d != IDLE);
            tag_req_q <= (state_d == INVAL);
            tag_idx_q <= (state_d == INVAL) ? idx_d : '0;
            tag_way_q <= {SET_ASSOC{state_d == INVAL}};
            ack_q     <= (state_d == DONE);
        end
    end

    assign tag_req_o   = tag_req_q;
    assign tag_we_o    = tag_req_q;
    assign tag_idx_o   = tag_idx_q;
    assign tag_way_o   = tag_way_q;
    assign busy_o      = busy_q;
    assign flush_ack_o = ack_q;
    assign flush_cnt_o = cnt_q;

endmodule

// File: tb/tb_cache_flush_seq.sv
// Directed bench for cache_flush_seq: default geometry plus 47-set and 4-way variants.
module tb_cache_flush_seq;

    logic        clk;
    logic        rst_n;
    logic        flush_req;
    logic        wbuf_empty;
    logic        tag_gnt;

    logic        tag_req, tag_we, busy, ack;
    logic [6:0]  tag_idx;
    logic [1:0]  tag_way;
    logic [15:0] cnt;

    logic        req47, we47, busy47, ack47;
    logic [5:0]  idx47;
    logic [1:0]  way47;
    logic [15:0] cnt47;

    logic        req32, we32, busy32, ack32;
    logic [4:0]  idx32;
    logic [3:0]  way32;
    logic [15:0] cnt32;

    int checks = 0;
    int errors = 0;
    bit rnd_gnt = 0;

    int cyc, writes, seq_err, way_err, we_err, acks, ack_cyc, busy_cyc, wlo_req, exp_idx;
    int writes47, seq47_err, ack47_cyc, exp47;
    int writes32, seq32_err, way32_err, exp32;

    cache_flush_seq dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_req_i(flush_req), .wbuf_empty_i(wbuf_empty),
        .tag_req_o(tag_req), .tag_gnt_i(tag_gnt), .tag_we_o(tag_we), .tag_idx_o(tag_idx),
        .tag_way_o(tag_way), .busy_o(busy), .flush_ack_o(ack), .flush_cnt_o(cnt)
    );

    cache_flush_seq #(.CACHE_BYTE_SIZE(1521)) dut47 (
        .clk_i(clk), .rst_ni(rst_n), .flush_req_i(flush_req), .wbuf_empty_i(wbuf_empty),
        .tag_req_o(req47), .tag_gnt_i(tag_gnt), .tag_we_o(we47), .tag_idx_o(idx47),
        .tag_way_o(way47), .busy_o(busy47), .flush_ack_o(ack47), .flush_cnt_o(cnt47)
    );

    cache_flush_seq #(.CACHE_BYTE_SIZE(2048), .SET_ASSOC(4)) dut32 (
        .clk_i(clk), .rst_ni(rst_n), .flush_req_i(flush_req), .wbuf_empty_i(wbuf_empty),
        .tag_req_o(req32), .tag_gnt_i(tag_gnt), .tag_we_o(we32), .tag_idx_o(idx32),
        .tag_way_o(way32), .busy_o(busy32), .flush_ack_o(ack32), .flush_cnt_o(cnt32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor on the falling edge: inputs and outputs are both settled here.
    always @(negedge clk) begin
        if (tag_req != tag_we) we_err++;
        if (tag_req) begin
            if (tag_way != 2'b11) way_err++;
            if (int'(tag_idx) != exp_idx) seq_err++;
            if (!wbuf_empty) wlo_req++;
            if (tag_gnt) begin
                writes++;
                exp_idx = (exp_idx == 69) ? 0 : exp_idx + 1;
            end
        end
        if (!busy) exp_idx = 0;
        if (busy) busy_cyc++;
        if (ack) begin
            acks++;
            ack_cyc = cyc;
        end

        if (req47) begin
            if (int'(idx47) != exp47) seq47_err++;
            if (tag_gnt) begin
                writes47++;
                exp47 = (exp47 == 46) ? 0 : exp47 + 1;
            end
        end
        if (!busy47) exp47 = 0;
        if (ack47) ack47_cyc = cyc;

        if (req32) begin
            if (way32 != 4'hF) way32_err++;
            if (int'(idx32) != exp32) seq32_err++;
            if (tag_gnt) begin
                writes32++;
                exp32 = (exp32 == 31) ? 0 : exp32 + 1;
            end
        end
        if (!busy32) exp32 = 0;
        cyc++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_gnt) tag_gnt = 1'($urandom_range(0, 1));
    endtask

    task automatic clear_stats();
        cyc = 0; writes = 0; seq_err = 0; way_err = 0; we_err = 0; acks = 0;
        ack_cyc = -1; busy_cyc = 0; wlo_req = 0; exp_idx = 0;
        writes47 = 0; seq47_err = 0; ack47_cyc = -1; exp47 = 0;
        writes32 = 0; seq32_err = 0; way32_err = 0; exp32 = 0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        if (busy) check("idle_timeout", 1, 0);
    endtask

    task automatic request();
        clear_stats();
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; flush_req = 1'b0; wbuf_empty = 1'b1; tag_gnt = 1'b1;
        clear_stats();
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_req", tag_req, 0);
        check("rst_way", tag_way, 0);
        check("rst_ack", ack, 0);
        check("rst_cnt", cnt, 0);
        rst_n = 1'b1;
        tick();
        check("post_rst_idx", tag_idx, 0);

        // Single flush, write buffer empty, grant always high.
        request();
        wait_idle(300);
        check("t1_writes", writes, 70);
        check("t1_seq", seq_err, 0);
        check("t1_way", way_err, 0);
        check("t1_we", we_err, 0);
        check("t1_acks", acks, 1);
        check("t1_ack_cyc", ack_cyc, 72);
        check("t1_busy_cyc", busy_cyc, 72);
        check("t1_idle_cyc", cyc, 73);
        check("t1_cnt", cnt, 1);
        check("n47_writes", writes47, 47);
        check("n47_seq", seq47_err, 0);
        check("n47_ack_cyc", ack47_cyc, 49);
        check("n47_cnt", cnt47, 1);
        check("n32_writes", writes32, 32);
        check("n32_seq", seq32_err, 0);
        check("n32_way", way32_err, 0);

        // Write buffer busy for 10 cycles after the request.
        clear_stats();
        flush_req = 1'b1; wbuf_empty = 1'b0;
        tick();
        flush_req = 1'b0;
        repeat (10) tick();
        wbuf_empty = 1'b1;
        wait_idle(300);
        check("t2_req_while_drain", wlo_req, 0);
        check("t2_ack_cyc", ack_cyc, 82);
        check("t2_writes", writes, 70);
        check("t2_cnt", cnt, 2);

        // Grant toggles randomly; index must hold until granted.
        rnd_gnt = 1'b1;
        request();
        wait_idle(1000);
        rnd_gnt = 1'b0;
        tag_gnt = 1'b1;
        check("t3_writes", writes, 70);
        check("t3_seq", seq_err, 0);
        check("t3_acks", acks, 1);
        check("t3_cnt", cnt, 3);

        // Extra request during DRAIN is absorbed.
        clear_stats();
        flush_req = 1'b1; wbuf_empty = 1'b0;
        tick();
        flush_req = 1'b0;
        tick();
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0; wbuf_empty = 1'b1;
        wait_idle(300);
        repeat (5) tick();
        check("t4a_acks", acks, 1);
        check("t4a_ack_cyc", ack_cyc, 74);
        check("t4a_no_reflush", busy, 0);
        check("t4a_cnt", cnt, 4);

        // Two requests during INVAL collapse into one re-flush.
        request();
        repeat (9) tick();
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        repeat (9) tick();
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        wait_idle(400);
        check("t4b_acks", acks, 2);
        check("t4b_ack_cyc", ack_cyc, 144);
        check("t4b_writes", writes, 140);
        check("t4b_seq", seq_err, 0);
        check("t4b_cnt", cnt, 6);

        // Reset in the middle of the walk.
        request();
        begin
            int n = 0;
            while (!(tag_req && tag_idx == 7'd35) && n < 100) begin
                tick();
                n++;
            end
        end
        check("t5_reached_35", tag_idx, 35);
        rst_n = 1'b0;
        tick();
        check("t5_busy", busy, 0);
        check("t5_req", tag_req, 0);
        check("t5_cnt", cnt, 0);
        check("t5_acks", acks, 0);
        check("t5_writes", writes, 36);
        rst_n = 1'b1;
        tick();
        request();
        wait_idle(300);
        check("t5_restart_writes", writes, 70);
        check("t5_restart_seq", seq_err, 0);
        check("t5_restart_acks", acks, 1);
        check("t5_restart_cnt", cnt, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_flush_seq.md
Name: cache_flush_seq

Overview:
- Sequences a full invalidation of one set-associative L1 cache, either the I-cache on fence.i or the write-through D-cache on fence.
- On a flush request it first waits for the D-cache write buffer to drain. It then walks every set, writing all ways' valid bits to zero through the tag-array port, and signals completion.
- It sits between the frontend/controller flush requests and the cache tag memory. While it runs, it holds off CPU lookups via busy_o.

Parameters:
- CACHE_BYTE_SIZE, 2261: cache capacity in bytes; need not be a power of two.
- SET_ASSOC, 2: number of ways.
- LINE_WIDTH, 128: line width in bits.
- NUM_SETS (derived, localparam), CACHE_BYTE_SIZE/(SET_ASSOC*LINE_WIDTH/8) using integer floor; 70 at defaults.
- IDX_W (derived, localparam), max(1,$clog2(NUM_SETS)); 7 at defaults.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_ni  in  1  synchronous active-low reset.
- flush_req_i  in  1  flush request; sampled every cycle; a 1 in any cycle is one request.
- wbuf_empty_i  in  1  write buffer holds no pending stores; tie to 1 for I-cache.
- tag_req_o  out  1  tag-array write request.
- tag_gnt_i  in  1  tag-array grant; a write is done in the cycle tag_req_o & tag_gnt_i.
- tag_we_o  out  1  write enable; equals tag_req_o.
- tag_idx_o  out  IDX_W  set index being invalidated.
- tag_way_o  out  SET_ASSOC  way mask; all ones while tag_req_o=1, else zero.
- busy_o  out  1  sequencer active; cache must not accept lookups.
- flush_ack_o  out  1  one-cycle pulse when a flush completes.
- flush_cnt_o  out  16  number of completed flushes; saturates at 16'hFFFF.

Behaviour:
- States: IDLE, DRAIN, INVAL, DONE. Registers: state, idx (IDX_W), redo (1), flush count (16).
- Reset (rst_ni=0 at a clock edge): state=IDLE, idx=0, redo=0, count=0. All outputs are 0 in the following cycle.
- Reset mid-operation abandons the flush with no ack. Sets already written stay invalid.
- IDLE:
  - busy_o=0, tag_req_o=0.
  - flush_req_i=1 -> DRAIN.
- DRAIN:
  - busy_o=1, tag_req_o=0.
  - wbuf_empty_i=1 -> INVAL with idx=0; otherwise stay.
  - flush_req_i in DRAIN is absorbed; the flush not yet started will cover it.
- INVAL:
  - busy_o=1, tag_req_o=tag_we_o=1, tag_idx_o=idx, tag_way_o='1.
  - No grant: hold all outputs stable.
  - Grant with idx==NUM_SETS-1 -> DONE, idx=0.
  - Grant otherwise: idx+1.
  - idx never exceeds NUM_SETS-1, even when NUM_SETS is not a power of two.
- DONE:
  - busy_o=1, flush_ack_o=1 for exactly this cycle, count increments (saturating).
  - redo=1 -> DRAIN and clear redo; else -> IDLE.
- Re-flush coalescing:
  - flush_req_i=1 while in INVAL or DONE sets redo=1. Multiple such requests collapse to one re-flush.
  - Each executed flush produces exactly one ack.
- Outputs are registered-state decodes only; there is no combinational path from tag_gnt_i or flush_req_i to any output.
- Latency with wbuf_empty_i=1 and tag_gnt_i=1 constant:
  - Request at cycle 0.
  - DRAIN at cycle 1; INVAL at cycles 2..(NUM_SETS+1).
  - DONE/ack at cycle NUM_SETS+2 (72 at defaults); IDLE at NUM_SETS+3.

Test Plan:
- Reset, then one-cycle flush_req_i with wbuf_empty_i=1 and tag_gnt_i=1 -> 70 writes with tag_idx_o 0..69, each tag_way_o=2'b11. Ack at cycle 72, busy_o high in cycles 1..72, flush_cnt_o=1.
- Hold wbuf_empty_i=0 for 10 cycles after the request -> no tag_req_o during those cycles. INVAL starts the cycle after wbuf_empty_i rises; ack is delayed by 10 cycles.
- Randomly deassert tag_gnt_i (~50%) -> tag_idx_o is held while ungranted, exactly 70 granted writes, no index skipped or repeated, one ack.
- Pulse flush_req_i during DRAIN -> single flush, one ack. Pulse it twice during INVAL -> after the first ack go directly to DRAIN, second full walk, second ack, flush_cnt_o=2.
- Assert rst_ni=0 at idx=35 -> next cycle busy_o=0 and tag_req_o=0, no ack, flush_cnt_o=0. A new request restarts at idx=0.
- Use CACHE_BYTE_SIZE=1521 -> NUM_SETS=47, last index 46. Use CACHE_BYTE_SIZE=2048, SET_ASSOC=4 -> NUM_SETS=32, tag_way_o=4'hF.
